// File: rtl/sly_pkg.sv
// Shared types and constants for the Simon sequence player.
package sly_pkg;

  // Two-bit color code, bit order matches the LED latch.
  typedef logic [1:0] color_t;

  localparam color_t COLOR_RED    = 2'd0;
  localparam color_t COLOR_BLUE   = 2'd1;
  localparam color_t COLOR_GREEN  = 2'd2;
  localparam color_t COLOR_YELLOW = 2'd3;

  // Player FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

endpackage

// File: rtl/hold_timer.sv
// Down-counter hold timer: load sets the count to LOAD, then it counts
// down to zero and stays there. expired is high while the count is zero,
// so a hold of N cycles uses LOAD = N-1.
module hold_timer #(
  parameter int unsigned LOAD = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int W = $clog2(LOAD + 2);
  localparam logic [W-1:0] LOAD_V = W'(LOAD);

  logic [W-1:0] count;

  // Load or count down, saturating at zero.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_V;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays a stored Simon color sequence through the LED latch strobe
// interface. Each step lights one LED for ON_CYCLES, then goes dark for
// OFF_CYCLES. Optional macro SEQUENCE_PLAYER_SPEEDUP_EN halves the ON hold
// (minimum 1) when more than DEPTH/2 entries are played.
module sequence_player
  import sly_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [1:0]                 wr_color,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] length,
  input  logic                       abort,
  output logic                       flash_led,
  output logic [1:0]                 color,
  output logic                       on_off,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n, idx_inc;
  logic [LW-1:0]   len_q, len_n, len_clamp;
  logic            flash_n, on_off_n, busy_n, done_n;
  color_t          color_n;
  logic            on_load, off_load, on_expired, off_expired, last_step;
  color_t          mem [DEPTH];

  assign idx_inc   = idx + AW'(1);
  assign len_clamp = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
  assign last_step = (LW'(idx) == len_q - LW'(1));

`ifdef SEQUENCE_PLAYER_SPEEDUP_EN
  localparam int unsigned ON_HALF = ((ON_CYCLES >> 1) == 0) ? 1 : (ON_CYCLES >> 1);
  logic fast_q, fast_n, on_full_expired, on_half_expired;

  hold_timer #(.LOAD(ON_CYCLES - 1)) u_on_full (
    .clock(clock), .reset(reset), .load(on_load), .expired(on_full_expired)
  );
  hold_timer #(.LOAD(ON_HALF - 1)) u_on_half (
    .clock(clock), .reset(reset), .load(on_load), .expired(on_half_expired)
  );
  assign on_expired = fast_q ? on_half_expired : on_full_expired;
  assign fast_n     = (state == ST_IDLE && start) ? (len_clamp > LW'(DEPTH / 2)) : fast_q;

  // Remember whether this playback uses the shortened ON hold.
  always_ff @(posedge clock) begin
    if (reset) fast_q <= 1'b0;
    else       fast_q <= fast_n;
  end
`else
  hold_timer #(.LOAD(ON_CYCLES - 1)) u_on_timer (
    .clock(clock), .reset(reset), .load(on_load), .expired(on_expired)
  );
`endif

  hold_timer #(.LOAD(OFF_CYCLES - 1)) u_off_timer (
    .clock(clock), .reset(reset), .load(off_load), .expired(off_expired)
  );

  // Sequence storage; writes only in IDLE and only when start is not taken.
  // NOTE: the memory is deliberately not reset so it maps onto plain RAM;
  // entries are meaningful only after being written.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && wr_en && !start) begin
      mem[wr_addr] <= wr_color;
    end
  end

  // Next-state and next-output logic.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    len_n    = len_q;
    flash_n  = 1'b0;
    color_n  = color;
    on_off_n = on_off;
    busy_n   = busy;
    done_n   = 1'b0;
    on_load  = 1'b0;
    off_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          len_n = len_clamp;
          idx_n = '0;
          if (len_clamp == '0) begin
            done_n = 1'b1;
          end else begin
            state_n  = ST_ON;
            flash_n  = 1'b1;
            on_off_n = 1'b1;
            color_n  = mem[0];
            busy_n   = 1'b1;
            on_load  = 1'b1;
          end
        end
      end
      ST_ON, ST_OFF: begin
        if (abort) begin
          state_n  = ST_IDLE;
          flash_n  = 1'b1;
          on_off_n = 1'b0;
          busy_n   = 1'b0;
        end else if (state == ST_ON) begin
          if (on_expired) begin
            state_n  = ST_OFF;
            flash_n  = 1'b1;
            on_off_n = 1'b0;
            off_load = 1'b1;
          end
        end else if (off_expired) begin
          if (last_step) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n  = ST_ON;
            idx_n    = idx_inc;
            flash_n  = 1'b1;
            on_off_n = 1'b1;
            color_n  = mem[idx_inc];
            on_load  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      len_q     <= '0;
      flash_led <= 1'b0;
      color     <= COLOR_RED;
      on_off    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      len_q     <= len_n;
      flash_led <= flash_n;
      color     <= color_n;
      on_off    <= on_off_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Directed self-checking bench for sequence_player (DEPTH=8, ON=4, OFF=2).
// Honors SEQUENCE_PLAYER_SPEEDUP_EN when computing the ON hold.
module tb_sequence_player;
  import sly_pkg::*;

  localparam int DEPTH = 8;
  localparam int ON_C  = 4;
  localparam int OFF_C = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [1:0] wr_color = '0;
  logic       start = 1'b0;
  logic [3:0] length = '0;
  logic       abort = 1'b0;
  logic       flash_led, on_off, busy, done;
  logic [1:0] color;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_col [DEPTH];

  sequence_player #(.DEPTH(DEPTH), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_color(wr_color), .start(start), .length(length), .abort(abort),
    .flash_led(flash_led), .color(color), .on_off(on_off), .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int on_hold(input int nsteps);
`ifdef SEQUENCE_PLAYER_SPEEDUP_EN
    return (nsteps > DEPTH / 2) ? ON_C / 2 : ON_C;
`else
    return ON_C;
`endif
  endfunction

  task automatic write_mem(input int addr, input logic [1:0] c);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_color = c;
    tick();
    wr_en = 1'b0;
    exp_col[addr] = c;
  endtask

  // Caller has just raised start (cycle T); checks cycles T+1..T+ncyc.
  // wr_at / st_at inject a write / a start during that cycle (0 = none).
  task automatic watch(input string tag, input int nsteps, input int ncyc,
                       input int wr_at, input int st_at);
    int per, p, step;
    logic act, e_flash, e_busy, e_done;
    per = on_hold(nsteps) + OFF_C;
    for (int t = 1; t <= ncyc; t++) begin
      tick();
      if (t == 1) begin start = 1'b0; abort = 1'b0; end
      if (wr_at != 0 && t == wr_at + 1) wr_en = 1'b0;
      if (st_at != 0 && t == st_at + 1) start = 1'b0;
      p       = (t - 1) % per;
      step    = (t - 1) / per;
      act     = (step < nsteps);
      e_flash = act && (p == 0 || p == on_hold(nsteps));
      e_busy  = (t < 1 + nsteps * per);
      e_done  = (t == 1 + nsteps * per);
      check($sformatf("%s t=%0d flash", tag, t), 32'(flash_led), 32'(e_flash));
      check($sformatf("%s t=%0d busy", tag, t), 32'(busy), 32'(e_busy));
      check($sformatf("%s t=%0d done", tag, t), 32'(done), 32'(e_done));
      if (e_flash) begin
        check($sformatf("%s t=%0d on_off", tag, t), 32'(on_off), 32'(p == 0));
        check($sformatf("%s t=%0d color", tag, t), 32'(color), 32'(exp_col[step]));
      end
      if (t == wr_at) begin wr_en = 1'b1; wr_addr = 3'd1; wr_color = COLOR_BLUE; end
      if (t == st_at) begin start = 1'b1; length = 4'd0; end
    end
  endtask

  initial begin
    // Reset state.
    tick(); tick();
    check("rst flash", 32'(flash_led), 0);
    check("rst color", 32'(color), 0);
    check("rst on_off", 32'(on_off), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    reset = 1'b0;
    tick();

    // Basic three-step playback.
    write_mem(0, COLOR_GREEN);
    write_mem(1, COLOR_RED);
    write_mem(2, COLOR_YELLOW);
    start = 1'b1; length = 4'd3;
    watch("seq3", 3, 20, 0, 0);

    // Zero length: immediate done, no strobe.
    start = 1'b1; length = 4'd0;
    tick();
    start = 1'b0;
    check("len0 done", 32'(done), 1);
    check("len0 flash", 32'(flash_led), 0);
    check("len0 busy", 32'(busy), 0);
    tick();
    check("len0 done drop", 32'(done), 0);

    // Write coinciding with start is discarded; mem[0] stays green.
    wr_en = 1'b1; wr_addr = 3'd0; wr_color = COLOR_BLUE;
    start = 1'b1; length = 4'd1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("cf t=1 flash", 32'(flash_led), 1);
    check("cf t=1 color", 32'(color), 32'(COLOR_GREEN));
    for (int t = 2; t <= 8; t++) tick();
    check("cf idle busy", 32'(busy), 0);

    // Length clamps to DEPTH.
    write_mem(3, COLOR_BLUE);
    write_mem(4, COLOR_GREEN);
    write_mem(5, COLOR_YELLOW);
    write_mem(6, COLOR_RED);
    write_mem(7, COLOR_BLUE);
    start = 1'b1; length = 4'd15;
    watch("clamp", 8, on_hold(8) == ON_C ? 50 : 1 + 8 * (on_hold(8) + OFF_C) + 1, 0, 0);

    // Abort during step 0, then replay with abort held in IDLE alongside start.
    start = 1'b1; length = 4'd3;
    watch("ab", 3, 3, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab flash", 32'(flash_led), 1);
    check("ab on_off", 32'(on_off), 0);
    check("ab busy", 32'(busy), 0);
    check("ab done", 32'(done), 0);
    tick();
    check("ab idle flash", 32'(flash_led), 0);
    check("ab idle done", 32'(done), 0);
    start = 1'b1; length = 4'd3; abort = 1'b1;
    watch("replay", 3, 20, 0, 0);

    // Write and start while busy are ignored.
    start = 1'b1; length = 4'd3;
    watch("busy", 3, 20, 3, 8);

    // Reset mid-playback.
    write_mem(1, COLOR_YELLOW);
    start = 1'b1; length = 4'd3;
    watch("rs", 3, 8, 0, 0);
    check("rs pre color", 32'(color), 32'(COLOR_YELLOW));
    reset = 1'b1;
    tick();
    check("rs flash", 32'(flash_led), 0);
    check("rs color", 32'(color), 0);
    check("rs on_off", 32'(on_off), 0);
    check("rs busy", 32'(busy), 0);
    check("rs done", 32'(done), 0);
    reset = 1'b0;
    tick(); tick();
    check("rs stays idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
